// File: rtl/bitrev_reorder_pkg.sv
// bitrev_reorder_pkg: shared FFT parameters, read FSM states and bit-reverse helper
package bitrev_reorder_pkg;
    localparam int FLOAT_LEN     = 32;
    localparam int BRAM_ADDR_LEN = 13;
    typedef enum logic {IDLE, READ} rd_state_e;
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        logic [31:0] s;
        r = '0;
        s = v;
        for (int i = 0; i < w; i++) begin
            r = {r[30:0], s[0]};
            s = s >> 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/bitrev_reorder_bram_dp.sv
// bram_dp: simple dual-port RAM, one write port and one registered read port
module bram_dp #(
    parameter int dw = 64,
    parameter int aw = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [aw-1:0] i_waddr,
    input  logic [dw-1:0] i_wdata,
    input  logic          i_re,
    input  logic [aw-1:0] i_raddr,
    output logic [dw-1:0] o_rdata
);
    logic [dw-1:0] r_mem [2**aw];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/bitrev_reorder.sv
// bitrev_reorder: ping-pong buffer turning bit-reversed FFT output into natural order
module bitrev_reorder
    import bitrev_reorder_pkg::*;
#(
    parameter int float_len     = FLOAT_LEN,
    parameter int bram_addr_len = BRAM_ADDR_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*float_len-1:0] data_in,
    input  logic                   data_in_valid,
    output logic [2*float_len-1:0] data_out,
    output logic                   data_out_valid,
    output logic                   data_out_last
);
    localparam int dw = 2 * float_len;
    rd_state_e                r_state, w_state_nxt;
    logic [bram_addr_len-1:0] r_wcnt, r_rcnt, w_wrev;
    logic                     r_wbank, r_rbank;
    logic [1:0]               r_full;
    logic                     w_wr_en, w_wr_last, w_rd_en, w_rd_last;
    logic                     r_rd_v, r_rd_last;
    logic [dw-1:0]            w_rdata;
    assign w_wrev    = bram_addr_len'(bitrev(32'(r_wcnt), bram_addr_len));
    assign w_wr_en   = data_in_valid && !r_full[r_wbank];
    assign w_wr_last = w_wr_en && (r_wcnt == '1);
    // IDLE issues address 0 the same cycle a bank turns full, keeping frames gapless
    always_comb begin
        w_rd_en     = (r_state == READ) || r_full[r_rbank];
        w_rd_last   = w_rd_en && (r_rcnt == '1);
        w_state_nxt = (w_rd_en && (!w_rd_last || r_full[~r_rbank])) ? READ : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wcnt         <= '0;
            r_rcnt         <= '0;
            r_wbank        <= 1'b0;
            r_rbank        <= 1'b0;
            r_full         <= '0;
            r_rd_v         <= 1'b0;
            r_rd_last      <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_en) r_wcnt <= r_wcnt + 1'b1;
            if (w_wr_last) r_wbank <= ~r_wbank;
            if (w_rd_en) r_rcnt <= r_rcnt + 1'b1;
            if (w_rd_last) r_rbank <= ~r_rbank;
            r_full         <= (r_full & ~({1'b0, w_rd_last} << r_rbank)) | ({1'b0, w_wr_last} << r_wbank);
            r_rd_v         <= w_rd_en;
            r_rd_last      <= w_rd_last;
            data_out       <= r_rd_v ? w_rdata : '0;
            data_out_valid <= r_rd_v;
            data_out_last  <= r_rd_v && r_rd_last;
        end
    end
    bram_dp #(.dw(dw), .aw(bram_addr_len + 1)) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr ({r_wbank, w_wrev}),
        .i_wdata (data_in),
        .i_re    (w_rd_en),
        .i_raddr ({r_rbank, r_rcnt}),
        .o_rdata (w_rdata)
    );
endmodule
